pram_ctrl: RTL and testbench

- Request-side controller directly upstream of the single-port block RAM (registered read, 1-cycle read latency, enable and write-enable only, no byte enables).
- Converts a valid/ready request channel into RAM port strobes and returns a valid/ready response channel.
- Implements byte-masked writes by read-modify-write.
- Allows one outstanding request at a time.

---
 rtl/pram_ctrl.sv | 156 +++++++++++++++
 tb/tb_pram_ctrl.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pram_ctrl.sv
// Request-side controller for a single-port, 1-cycle-latency block RAM.
// One request in flight; byte-masked writes are done by read-modify-write.
module pram_ctrl #(
    parameter int DATA_WIDTH = 64,
    parameter int DEPTH      = 1024,
    parameter int ADDR_WIDTH = $clog2(DEPTH),
    parameter int MASK_WIDTH = DATA_WIDTH / 8
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_wen,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    input  logic [MASK_WIDTH-1:0] req_wmask,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic                  resp_err,
    output logic                  ram_en,
    output logic                  ram_we,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_din,
    input  logic [DATA_WIDTH-1:0] ram_dout
);

    typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

    localparam logic [ADDR_WIDTH:0] DEPTH_X = (ADDR_WIDTH + 1)'(DEPTH);

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [MASK_WIDTH-1:0] wmask_q, wmask_d;
    logic                  wen_q, wen_d;
    logic                  resp_valid_q, resp_valid_d;
    logic                  resp_err_q, resp_err_d;
    logic [DATA_WIDTH-1:0] resp_rdata_q, resp_rdata_d;

    logic                  addr_oob;
    logic                  mask_full;
    logic                  mask_zero;
    logic [DATA_WIDTH-1:0] merged;

    assign addr_oob  = ({1'b0, req_addr} >= DEPTH_X);
    assign mask_full = &req_wmask;
    assign mask_zero = ~|req_wmask;

    always_comb begin
        merged = ram_dout;
        for (int i = 0; i < MASK_WIDTH; i++) begin
            if (wmask_q[i]) merged[8*i +: 8] = wdata_q[8*i +: 8];
        end
    end

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        wmask_d      = wmask_q;
        wen_d        = wen_q;
        resp_valid_d = resp_valid_q;
        resp_err_d   = resp_err_q;
        resp_rdata_d = resp_rdata_q;
        req_ready    = 1'b0;
        ram_en       = 1'b0;
        ram_we       = 1'b0;
        ram_addr     = addr_q;
        ram_din      = wdata_q;

        case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                ram_addr  = req_addr;
                ram_din   = req_wdata;
                if (req_valid) begin
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    wmask_d = req_wmask;
                    wen_d   = req_wen;
                    if (addr_oob) begin
                        resp_valid_d = 1'b1;
                        resp_err_d   = 1'b1;
                        resp_rdata_d = '0;
                        state_d      = RESP;
                    end else if (!req_wen || !(mask_full || mask_zero)) begin
                        // reads and partial writes both start with a RAM read
                        ram_en  = 1'b1;
                        state_d = RD;
                    end else begin
                        ram_en       = mask_full;
                        ram_we       = mask_full;
                        resp_valid_d = 1'b1;
                        resp_err_d   = 1'b0;
                        resp_rdata_d = '0;
                        state_d      = RESP;
                    end
                end
            end
            RD: begin
                if (wen_q) begin
                    wdata_d = merged;
                    state_d = WR;
                end else begin
                    resp_valid_d = 1'b1;
                    resp_err_d   = 1'b0;
                    resp_rdata_d = ram_dout;
                    state_d      = RESP;
                end
            end
            WR: begin
                ram_en       = 1'b1;
                ram_we       = 1'b1;
                resp_valid_d = 1'b1;
                resp_err_d   = 1'b0;
                resp_rdata_d = '0;
                state_d      = RESP;
            end
            RESP: begin
                if (resp_ready) begin
                    resp_valid_d = 1'b0;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            wdata_q      <= '0;
            wmask_q      <= '0;
            wen_q        <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= '0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            wmask_q      <= wmask_d;
            wen_q        <= wen_d;
            resp_valid_q <= resp_valid_d;
            resp_err_q   <= resp_err_d;
            resp_rdata_q <= resp_rdata_d;
        end
    end

    assign resp_valid = resp_valid_q;
    assign resp_err   = resp_err_q;
    assign resp_rdata = resp_rdata_q;

endmodule

// File: tb/tb_pram_ctrl.sv
// Bench for pram_ctrl: behavioural RAM, transaction-level reference memory,
// directed scenarios plus a randomized mix with random response backpressure.
module tb_pram_ctrl;

    localparam int DW = 64;
    localparam int DEPTH = 1000;
    localparam int AW = 10;
    localparam int MW = 8;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic          req_wen = 1'b0;
    logic [AW-1:0] req_addr = '0;
    logic [DW-1:0] req_wdata = '0;
    logic [MW-1:0] req_wmask = '0;
    logic          resp_valid;
    logic          resp_ready = 1'b1;
    logic [DW-1:0] resp_rdata;
    logic          resp_err;
    logic          ram_en, ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_din;
    logic [DW-1:0] ram_dout = '0;

    logic [DW-1:0] ram     [0:1023];
    logic [DW-1:0] mem_ref [0:1023];

    int vec = 0, fails = 0;
    int cyc = 0, en_cnt = 0, we_cnt = 0, last_we_cyc = -1;

    pram_ctrl #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_wmask(req_wmask),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
        .ram_din(ram_din), .ram_dout(ram_dout)
    );

    always #5 clock = ~clock;

    always @(posedge clock) begin
        cyc <= cyc + 1;
        if (ram_en) begin
            en_cnt <= en_cnt + 1;
            if (ram_we) begin
                ram[ram_addr] <= ram_din;
                we_cnt        <= we_cnt + 1;
                last_we_cyc   <= cyc;
            end else begin
                ram_dout <= ram[ram_addr];
            end
        end
    end

    // Expected outcome of one transaction, derived from the request alone.
    task automatic model(input logic wen, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                         input logic [MW-1:0] wm, output logic [DW-1:0] rd, output logic er,
                         output int lat, output int ens, output int wes);
        rd = '0; er = 1'b0;
        if (int'(a) >= DEPTH) begin
            er = 1'b1; lat = 1; ens = 0; wes = 0;
        end else if (!wen) begin
            rd = mem_ref[a]; lat = 2; ens = 1; wes = 0;
        end else begin
            for (int b = 0; b < MW; b++)
                if (wm[b]) mem_ref[a][8*b +: 8] = wd[8*b +: 8];
            if (wm == '0)         begin lat = 1; ens = 0; wes = 0; end
            else if (wm == '1)    begin lat = 1; ens = 1; wes = 1; end
            else                  begin lat = 3; ens = 2; wes = 1; end
        end
    endtask

    task automatic xact(input logic wen, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                        input logic [MW-1:0] wm, input int hold,
                        output logic [DW-1:0] rd, output logic er, output int lat,
                        output int acc, output int ens, output int wes);
        int en0, we0, n;
        en0 = en_cnt; we0 = we_cnt;
        @(negedge clock);
        req_valid = 1'b1; req_wen = wen; req_addr = a; req_wdata = wd; req_wmask = wm;
        resp_ready = (hold == 0);
        n = 0;
        while (!req_ready && n < 20) begin @(negedge clock); n++; end
        @(posedge clock); #1;
        acc = cyc;
        req_valid = 1'b0; req_addr = AW'($urandom); req_wdata = {$urandom, $urandom};
        req_wmask = MW'($urandom); req_wen = 1'($urandom);
        lat = 1;
        while (!resp_valid && lat < 10) begin @(posedge clock); #1; lat++; end
        rd = resp_rdata; er = resp_err;
        for (int h = 0; h < hold; h++) begin
            @(posedge clock); #1;
            vec++;
            if (resp_valid !== 1'b1 || resp_rdata !== rd || resp_err !== er ||
                req_ready !== 1'b0 || ram_en !== 1'b0) begin
                fails++;
                $display("FAIL hold: valid=%b rdata=%h err=%b rdy=%b en=%b, required 1 %h %b 0 0",
                         resp_valid, resp_rdata, resp_err, req_ready, ram_en, rd, er);
            end
        end
        resp_ready = 1'b1;
        @(posedge clock); #1;
        vec++;
        if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
            fails++;
            $display("FAIL release: valid=%b req_ready=%b, required 0 1", resp_valid, req_ready);
        end
        ens = en_cnt - en0; wes = we_cnt - we0;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        vec++;
        if (resp_valid !== 1'b0 || resp_err !== 1'b0 || resp_rdata !== '0) begin
            fails++;
            $display("FAIL reset_resp: valid=%b err=%b rdata=%h, required 0 0 0", resp_valid, resp_err, resp_rdata);
        end
        vec++;
        if (req_ready !== 1'b1 || ram_en !== 1'b0 || ram_we !== 1'b0) begin
            fails++;
            $display("FAIL reset_port: ready=%b en=%b we=%b, required 1 0 0", req_ready, ram_en, ram_we);
        end
    endtask

    task automatic test_full_write;
        logic [DW-1:0] rd, erd; logic er, eer; int lat, elat, acc, ens, eens, wes, ewes;
        model(1'b1, 10'd5, 64'h1122334455667788, 8'hFF, erd, eer, elat, eens, ewes);
        xact(1'b1, 10'd5, 64'h1122334455667788, 8'hFF, 0, rd, er, lat, acc, ens, wes);
        vec++;
        if (rd !== erd || er !== eer || lat !== elat || ens !== eens || wes !== ewes) begin
            fails++;
            $display("FAIL full_write: rd=%h err=%b lat=%0d en=%0d we=%0d, required %h %b %0d %0d %0d",
                     rd, er, lat, ens, wes, erd, eer, elat, eens, ewes);
        end
        model(1'b0, 10'd5, '0, '0, erd, eer, elat, eens, ewes);
        xact(1'b0, 10'd5, '0, '0, 0, rd, er, lat, acc, ens, wes);
        vec++;
        if (rd !== 64'h1122334455667788 || er !== 1'b0 || lat !== 2 || ens !== 1 || wes !== 0) begin
            fails++;
            $display("FAIL read_after_full: rd=%h err=%b lat=%0d en=%0d we=%0d, required 1122334455667788 0 2 1 0",
                     rd, er, lat, ens, wes);
        end
    endtask

    task automatic test_partial_write;
        logic [DW-1:0] rd, erd; logic er, eer; int lat, elat, acc, ens, eens, wes, ewes;
        ram[7] = '1; mem_ref[7] = '1;
        model(1'b1, 10'd7, '0, 8'h0F, erd, eer, elat, eens, ewes);
        xact(1'b1, 10'd7, '0, 8'h0F, 0, rd, er, lat, acc, ens, wes);
        vec++;
        if (rd !== erd || lat !== 3 || wes !== 1 || ens !== 2 || last_we_cyc !== acc + 1) begin
            fails++;
            $display("FAIL partial_write: rd=%h lat=%0d we=%0d en=%0d we_at=%0d, required 0 3 1 2 %0d",
                     rd, lat, wes, ens, last_we_cyc, acc + 1);
        end
        model(1'b0, 10'd7, '0, '0, erd, eer, elat, eens, ewes);
        xact(1'b0, 10'd7, '0, '0, 0, rd, er, lat, acc, ens, wes);
        vec++;
        if (rd !== 64'hFFFFFFFF00000000 || rd !== erd || er !== 1'b0) begin
            fails++;
            $display("FAIL partial_readback: rd=%h err=%b, required ffffffff00000000 0", rd, er);
        end
    endtask

    task automatic test_backpressure;
        logic [DW-1:0] rd, erd; logic er, eer; int lat, elat, acc, ens, eens, wes, ewes;
        model(1'b0, 10'd5, '0, '0, erd, eer, elat, eens, ewes);
        xact(1'b0, 10'd5, '0, '0, 5, rd, er, lat, acc, ens, wes);
        vec++;
        if (rd !== erd || er !== 1'b0 || lat !== 2 || ens !== 1) begin
            fails++;
            $display("FAIL backpressure: rd=%h err=%b lat=%0d en=%0d, required %h 0 2 1", rd, er, lat, ens, erd);
        end
    endtask

    task automatic test_error;
        logic [DW-1:0] rd, erd; logic er, eer; int lat, elat, acc, ens, eens, wes, ewes;
        model(1'b0, 10'd1000, '0, '0, erd, eer, elat, eens, ewes);
        xact(1'b0, 10'd1000, '0, '0, 0, rd, er, lat, acc, ens, wes);
        vec++;
        if (rd !== '0 || er !== 1'b1 || lat !== 1 || ens !== 0) begin
            fails++;
            $display("FAIL err_read: rd=%h err=%b lat=%0d en=%0d, required 0 1 1 0", rd, er, lat, ens);
        end
        model(1'b1, 10'd1010, 64'hDEAD, 8'hFF, erd, eer, elat, eens, ewes);
        xact(1'b1, 10'd1010, 64'hDEAD, 8'hFF, 0, rd, er, lat, acc, ens, wes);
        vec++;
        if (rd !== erd || er !== eer || lat !== elat || ens !== eens || wes !== ewes) begin
            fails++;
            $display("FAIL err_write: rd=%h err=%b lat=%0d en=%0d we=%0d, required %h %b %0d %0d %0d",
                     rd, er, lat, ens, wes, erd, eer, elat, eens, ewes);
        end
    endtask

    task automatic test_reset_mid;
        logic [DW-1:0] rd, erd; logic er, eer; int lat, elat, acc, ens, eens, wes, ewes, we0;
        ram[3] = {8{8'hAA}}; mem_ref[3] = {8{8'hAA}};
        we0 = we_cnt;
        @(negedge clock);
        req_valid = 1'b1; req_wen = 1'b1; req_addr = 10'd3; req_wdata = '0; req_wmask = 8'h0F;
        @(posedge clock); #1;
        req_valid = 1'b0;
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        vec++;
        if (resp_valid !== 1'b0 || ram_en !== 1'b0 || ram_we !== 1'b0 || req_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset_mid: valid=%b en=%b we=%b rdy=%b, required 0 0 0 1", resp_valid, ram_en, ram_we, req_ready);
        end
        repeat (3) @(posedge clock);
        #1;
        vec++;
        if (we_cnt !== we0 || resp_valid !== 1'b0) begin
            fails++;
            $display("FAIL reset_mid_nowrite: writes=%0d valid=%b, required 0 0", we_cnt - we0, resp_valid);
        end
        model(1'b0, 10'd3, '0, '0, erd, eer, elat, eens, ewes);
        xact(1'b0, 10'd3, '0, '0, 0, rd, er, lat, acc, ens, wes);
        vec++;
        if (rd !== {8{8'hAA}} || rd !== erd) begin
            fails++;
            $display("FAIL reset_mid_readback: rd=%h, required aaaaaaaaaaaaaaaa", rd);
        end
    endtask

    task automatic test_back_to_back;
        logic [DW-1:0] rd, erd; logic er, eer; int lat, elat, acc, ens, eens, wes, ewes, prev;
        model(1'b1, 10'd20, 64'h55, 8'h00, erd, eer, elat, eens, ewes);
        xact(1'b1, 10'd20, 64'h55, 8'h00, 0, rd, er, lat, acc, ens, wes);
        vec++;
        if (rd !== '0 || er !== 1'b0 || lat !== 1 || ens !== 0 || wes !== 0) begin
            fails++;
            $display("FAIL zero_mask: rd=%h err=%b lat=%0d en=%0d we=%0d, required 0 0 1 0 0", rd, er, lat, ens, wes);
        end
        prev = 0;
        for (int i = 0; i < 10; i++) begin
            model(1'b0, AW'(i), '0, '0, erd, eer, elat, eens, ewes);
            xact(1'b0, AW'(i), '0, '0, 0, rd, er, lat, acc, ens, wes);
            vec++;
            if (rd !== erd || er !== 1'b0 || lat !== 2 || (i > 0 && acc - prev !== 3)) begin
                fails++;
                $display("FAIL b2b[%0d]: rd=%h err=%b lat=%0d gap=%0d, required %h 0 2 3", i, rd, er, lat, acc - prev, erd);
            end
            prev = acc;
        end
    endtask

    task automatic test_random;
        logic [DW-1:0] rd, erd, wd; logic er, eer, wen; logic [AW-1:0] a; logic [MW-1:0] wm;
        int lat, elat, acc, ens, eens, wes, ewes, hold;
        for (int t = 0; t < 300; t++) begin
            wen = 1'($urandom);
            a = ($urandom_range(0, 9) == 0) ? AW'($urandom_range(995, 1023)) : AW'($urandom_range(0, 15));
            wd = {$urandom, $urandom};
            case ($urandom_range(0, 3))
                0: wm = '0;
                1: wm = '1;
                default: wm = MW'($urandom);
            endcase
            hold = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
            model(wen, a, wd, wm, erd, eer, elat, eens, ewes);
            xact(wen, a, wd, wm, hold, rd, er, lat, acc, ens, wes);
            vec++;
            if (rd !== erd || er !== eer || lat !== elat || ens !== eens || wes !== ewes) begin
                fails++;
                $display("FAIL rand[%0d] wen=%b a=%0d m=%h: rd=%h err=%b lat=%0d en=%0d we=%0d, required %h %b %0d %0d %0d",
                         t, wen, a, wm, rd, er, lat, ens, wes, erd, eer, elat, eens, ewes);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) begin
            ram[i] = {$urandom, $urandom};
            mem_ref[i] = ram[i];
        end
        test_reset();
        test_full_write();
        test_partial_write();
        test_backpressure();
        test_error();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vec, fails);
        $finish;
    end

endmodule
